sigmoid_deriv_sched: RTL and testbench

SIGMOID_DERIV_SCHED -- requirements
Module: sigmoid_deriv_sched

---
 rtl/sigmoid_deriv_sched.sv | 96 +++++++++
 tb/tb_sigmoid_deriv_sched.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sigmoid_deriv_sched.sv
// sigmoid_deriv_sched: round-robin sharing of one fixed-latency sigmoid_deriv unit among NREQ requesters.
// Define SIGD_SCHED_PRIO_EN to give requester 0 strict priority over the round-robin group.
module sigmoid_deriv_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [32*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [31:0]              du_in,
  output logic                     du_in_valid,
  input  logic [31:0]              du_out,
  output logic                     resp_valid,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [31:0]              resp_data,
  output logic                     idle
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0]   ptr_q, ptr_d, gid, j;
  logic [NREQ-1:0] vmask, gnt;
  logic            hit;
  logic [31:0]     du_in_q, resp_data_q;
  logic [IW-1:0]   du_id_q, resp_id_q;
  logic            du_valid_q, resp_valid_q, idle_q, idle_d;
  logic [LAT-1:0]  tv_q, tv_d;
  logic [IW-1:0]   tid_q [LAT];
  always_comb begin
    vmask = (reset || !en) ? '0 : req_valid;
    gnt = '0;
    gid = '0;
    hit = 1'b0;
    j = '0;
`ifdef SIGD_SCHED_PRIO_EN
    if (vmask[0]) begin
      gnt[0] = 1'b1;
      hit = 1'b1;
    end
`endif
    for (int o = 0; o < NREQ; o++) begin
      j = IW'((int'(ptr_q) + o) % NREQ);
      if (!hit && vmask[j]) begin
        gnt[j] = 1'b1;
        gid = j;
        hit = 1'b1;
      end
    end
    ptr_d = ptr_q;
`ifdef SIGD_SCHED_PRIO_EN
    if (hit && gid != '0) ptr_d = (int'(gid) == NREQ-1) ? '0 : gid + IW'(1);
`else
    if (hit) ptr_d = (int'(gid) == NREQ-1) ? '0 : gid + IW'(1);
`endif
    // The tag pipe takes its input from the registered du_in_valid so its exit lines up with du_out.
    tv_d = LAT'({tv_q, du_valid_q});
    idle_d = ~(|tv_d | hit | tv_q[LAT-1]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      tv_q <= '0;
      du_valid_q <= 1'b0;
      du_in_q <= '0;
      du_id_q <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q <= '0;
      resp_data_q <= '0;
      idle_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
      du_valid_q <= hit;
      if (hit) begin
        du_in_q <= req_data[32*gid +: 32];
        du_id_q <= gid;
      end
      tv_q <= tv_d;
      resp_valid_q <= tv_q[LAT-1];
      if (tv_q[LAT-1]) begin
        resp_id_q <= tid_q[LAT-1];
        resp_data_q <= du_out;
      end
      idle_q <= idle_d;
    end
    tid_q[0] <= du_id_q;
    for (int s = 1; s < LAT; s++) tid_q[s] <= tid_q[s-1];
  end
  assign req_ready = gnt;
  assign du_in = du_in_q;
  assign du_in_valid = du_valid_q;
  assign resp_valid = resp_valid_q;
  assign resp_id = resp_id_q;
  assign resp_data = resp_data_q;
  assign idle = idle_q;
endmodule

// File: tb/tb_sigmoid_deriv_sched.sv
// tb_sigmoid_deriv_sched: directed vectors with a response scoreboard; unit modelled as a LAT-cycle delay.
module tb_sigmoid_deriv_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 4;
  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            en = 1'b0;
  logic [3:0]      req_valid = '0;
  logic [127:0]    req_data = '0;
  logic [3:0]      req_ready;
  logic [31:0]     du_in, du_out;
  logic            du_in_valid, resp_valid, idle;
  logic [1:0]      resp_id;
  logic [31:0]     resp_data;
  logic [31:0]     pipe [LAT];
  int              cyc = 0;
  int              tests = 0;
  int              fails = 0;
  int              seq = 0;
  typedef struct { int t; int id; logic [31:0] d; } exp_t;
  exp_t            q [$];
`ifdef SIGD_SCHED_PRIO_EN
  logic [31:0] g2 = 32'h1111_1111;
  logic [15:0] g3 = 16'h4111;
  logic [7:0]  g4 = 8'h11;
`else
  logic [31:0] g2 = 32'h8421_8421;
  logic [15:0] g3 = 16'h4141;
  logic [7:0]  g4 = 8'h18;
`endif

  sigmoid_deriv_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .du_in(du_in), .du_in_valid(du_in_valid), .du_out(du_out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .idle(idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    pipe[0] <= du_in;
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
  end
  assign du_out = pipe[LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One stimulus cycle: drive, check the grant, and record the response it must produce.
  task automatic drive(input logic [3:0] v, input logic e, input logic [3:0] exp_rdy,
                       input bit push, input logic [31:0] d0);
    @(negedge clk);
    req_valid = v;
    en = e;
    for (int i = 0; i < NREQ; i++)
      req_data[32*i +: 32] = (i == 0 && d0 != 0) ? d0 : {4'(i + 1), 28'(seq)};
    seq++;
    #1 chk("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
    if (push)
      for (int i = 0; i < NREQ; i++)
        if (exp_rdy[i]) q.push_back('{cyc + LAT + 2, i, req_data[32*i +: 32]});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    en = 1'b1;
    req_valid = '1;
    #1 chk("ready_in_reset", {60'd0, req_ready}, 64'd0);
    @(negedge clk);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_id", {62'd0, resp_id}, 64'd0);
    chk("rst_resp_data", {32'd0, resp_data}, 64'd0);
    chk("rst_du_in_valid", {63'd0, du_in_valid}, 64'd0);
    chk("rst_du_in", {32'd0, du_in}, 64'd0);
    chk("rst_idle", {63'd0, idle}, 64'd1);
    reset = 1'b0;
    req_valid = '0;
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got id %0d data %0h expected no response (cycle %0d)",
                 resp_id, resp_data, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_id", {62'd0, resp_id}, 64'(e.id));
        chk("resp_data", {32'd0, resp_data}, {32'd0, e.d});
        chk("resp_cycle", 64'(cyc), 64'(e.t));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    apply_reset();
    // Single operand 0.9 from requester 0
    drive(4'b0001, 1'b1, 4'b0001, 1'b1, 32'h3F666666);
    @(negedge clk);
    req_valid = '0;
    chk("t1_du_in_valid", {63'd0, du_in_valid}, 64'd1);
    chk("t1_du_in", {32'd0, du_in}, {32'd0, 32'h3F666666});
    @(negedge clk);
    chk("t1_du_in_valid_low", {63'd0, du_in_valid}, 64'd0);
    chk("t1_du_in_hold", {32'd0, du_in}, {32'd0, 32'h3F666666});
    chk("t1_busy", {63'd0, idle}, 64'd0);
    repeat (8) @(negedge clk);
    chk("t1_idle", {63'd0, idle}, 64'd1);
    chk("t1_drained", 64'(q.size()), 64'd0);
    // Full-rate burst from all four requesters
    apply_reset();
    for (int n = 0; n < 8; n++) drive(4'b1111, 1'b1, g2[4*n +: 4], 1'b1, 32'd0);
    drive(4'b0000, 1'b1, 4'b0000, 1'b1, 32'd0);
    // Requesters 0 and 2 contend, then 0 drops
    for (int n = 0; n < 3; n++) drive(4'b0101, 1'b1, g3[4*n +: 4], 1'b1, 32'd0);
    drive(4'b0100, 1'b1, g3[12 +: 4], 1'b1, 32'd0);
    drive(4'b0000, 1'b1, 4'b0000, 1'b1, 32'd0);
    repeat (10) @(negedge clk);
    chk("t3_drained", 64'(q.size()), 64'd0);
    // en dropped two cycles into a burst
    drive(4'b1111, 1'b1, g4[0 +: 4], 1'b1, 32'd0);
    drive(4'b1111, 1'b1, g4[4 +: 4], 1'b1, 32'd0);
    for (int n = 0; n < 3; n++) drive(4'b1111, 1'b0, 4'b0000, 1'b1, 32'd0);
    drive(4'b0000, 1'b0, 4'b0000, 1'b1, 32'd0);
    repeat (12) @(negedge clk);
    chk("t4_drained", 64'(q.size()), 64'd0);
    chk("t4_idle", {63'd0, idle}, 64'd1);
    // Reset while three operands are in flight; last grant leaves ptr at 2
    drive(4'b1000, 1'b1, 4'b1000, 1'b0, 32'd0);
    drive(4'b0100, 1'b1, 4'b0100, 1'b0, 32'd0);
    drive(4'b0010, 1'b1, 4'b0010, 1'b0, 32'd0);
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, 32'd0);
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, 32'd0);
    apply_reset();
    repeat (10) @(negedge clk);
    chk("t5_idle_after_reset", {63'd0, idle}, 64'd1);
    drive(4'b1111, 1'b1, 4'b0001, 1'b1, 32'd0);
    drive(4'b0000, 1'b1, 4'b0000, 1'b1, 32'd0);
    repeat (10) @(negedge clk);
    chk("final_drained", 64'(q.size()), 64'd0);
    chk("final_idle", {63'd0, idle}, 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
